// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the round-robin divider arbiter: FSM states,
// divide step count and the RPM readback numerator.
package div_arbiter_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;

   localparam int unsigned DIV_STEPS     = 32;
   localparam logic [31:0] RPM_NUMERATOR = 32'd64_000_000;

endpackage

// File: rtl/div_arbiter_if.sv
// Request/result bundle between the requesters and the shared divider.
interface div_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned NUM_W = 32,
   parameter int unsigned DEN_W = 16
);
   logic [NREQ-1:0]       req;
   logic [NREQ*NUM_W-1:0] num;
   logic [NREQ*DEN_W-1:0] den;
   logic [NREQ-1:0]       ack;
   logic [NREQ-1:0]       done;
   logic [NUM_W-1:0]      quot;
   logic [DEN_W-1:0]      rem;
   logic                  div0;
   logic                  busy;

   modport master (
      output req, num, den,
      input  ack, done, quot, rem, div0, busy
   );

   modport slave (
      input  req, num, den,
      output ack, done, quot, rem, div0, busy
   );
endinterface

// File: rtl/div_arbiter_seq_divider.sv
// Iterative restoring divider: load captures operands, each step retires
// one quotient bit; last flags the final step.
module seq_divider #(
   parameter int unsigned NUM_W = 32,
   parameter int unsigned DEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [NUM_W-1:0] quot,
   output logic [DEN_W-1:0] rem,
   output logic             div0,
   output logic             last
);
   localparam int unsigned CNT_W = $clog2(NUM_W);

   logic [NUM_W-1:0] nq;
   logic [DEN_W-1:0] pr;
   logic [DEN_W-1:0] dv;
   logic [CNT_W-1:0] cnt;
   logic [DEN_W:0]   pr_sh;
   logic             ge;

   // Numerator bits shift out the top while quotient bits shift in below;
   // a zero divisor always "fits", giving all-ones and the low numerator bits.
   always_comb begin
      pr_sh = {pr, nq[NUM_W-1]};
      ge    = (pr_sh >= {1'b0, dv});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nq  <= '0;
         pr  <= '0;
         dv  <= '0;
         cnt <= '0;
      end else if (load) begin
         nq  <= num;
         pr  <= '0;
         dv  <= den;
         cnt <= '0;
      end else if (step) begin
         nq  <= {nq[NUM_W-2:0], ge};
         pr  <= ge ? DEN_W'(pr_sh - {1'b0, dv}) : pr_sh[DEN_W-1:0];
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign quot = nq;
   assign rem  = pr;
   assign div0 = (dv == '0);
   assign last = (cnt == CNT_W'(NUM_W - 1));

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative 32/16 divider among NREQ requesters, granted
// round-robin; 33 cycles from ack to done.
module div_arbiter
   import div_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned NUM_W = DIV_STEPS,
   parameter int unsigned DEN_W = 16
) (
   input logic         clk,
   input logic         reset,
   div_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(NREQ);

   div_state_t       state, state_next;
   logic [PTR_W-1:0] rr_ptr, gnt;
   logic             gnt_valid;
   logic [NREQ-1:0]  ack_next, done_next;
   logic             load, step, last;
   logic [NUM_W-1:0] sel_num, dq;
   logic [DEN_W-1:0] sel_den, dr;
   logic             dz;

   // Search starts just past the last grant and wraps, so the nearest
   // requester in rotation order wins.
   always_comb begin
      int unsigned idx;
      gnt       = '0;
      gnt_valid = 1'b0;
      for (int unsigned off = 1; off <= NREQ; off++) begin
         idx = (32'(rr_ptr) + off) % NREQ;
         if (!gnt_valid && bus.req[PTR_W'(idx)]) begin
            gnt       = PTR_W'(idx);
            gnt_valid = 1'b1;
         end
      end
      sel_num = bus.num[gnt*NUM_W +: NUM_W];
      sel_den = bus.den[gnt*DEN_W +: DEN_W];
   end

   always_comb begin
      state_next = state;
      ack_next   = '0;
      done_next  = '0;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         DIV_IDLE: begin
            if (gnt_valid) begin
               load          = 1'b1;
               ack_next[gnt] = 1'b1;
               state_next    = DIV_CALC;
            end
         end
         DIV_CALC: begin
            step = 1'b1;
            if (last) state_next = DIV_DONE;
         end
         DIV_DONE: begin
            done_next[rr_ptr] = 1'b1;
            state_next        = DIV_IDLE;
         end
         default: state_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= DIV_IDLE;
         rr_ptr   <= PTR_W'(NREQ - 1);
         bus.ack  <= '0;
         bus.done <= '0;
         bus.quot <= '0;
         bus.rem  <= '0;
         bus.div0 <= 1'b0;
      end else begin
         state    <= state_next;
         bus.ack  <= ack_next;
         bus.done <= done_next;
         if (load) rr_ptr <= gnt;
         if (state == DIV_DONE) begin
            bus.quot <= dq;
            bus.rem  <= dr;
            bus.div0 <= dz;
         end
      end
   end

   assign bus.busy = (state != DIV_IDLE);

   seq_divider #(
      .NUM_W(NUM_W),
      .DEN_W(DEN_W)
   ) u_div (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .step (step),
      .num  (sel_num),
      .den  (sel_den),
      .quot (dq),
      .rem  (dr),
      .div0 (dz),
      .last (last)
   );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: vector table, scoreboard of expected
// results, and sequences for contention, fairness and mid-operation reset.
module tb_div_arbiter;
   import div_arbiter_pkg::*;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned NUM_W = 32;
   localparam int unsigned DEN_W = 16;

   typedef struct {
      int unsigned      idx;
      logic [NUM_W-1:0] n;
      logic [DEN_W-1:0] d;
      logic [NUM_W-1:0] q;
      logic [DEN_W-1:0] r;
      logic             z;
   } vec_t;

   typedef struct {
      int unsigned      idx;
      logic [NUM_W-1:0] q;
      logic [DEN_W-1:0] r;
      logic             z;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   div_arbiter_if #(.NREQ(NREQ), .NUM_W(NUM_W), .DEN_W(DEN_W)) bus ();

   div_arbiter #(.NREQ(NREQ), .NUM_W(NUM_W), .DEN_W(DEN_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;
   int unsigned cyc    = 0;
   int unsigned done_cnt = 0;
   int unsigned ack_cyc [NREQ];
   int unsigned ack_log [$];
   int unsigned done_cyc [$];
   exp_t        sb [$];
   vec_t        vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_msg(input string name);
      n_vec++;
      n_miss++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // Advance to the next falling edge and monitor ack/done there.
   task automatic tick();
      int unsigned didx;
      exp_t e;
      @(negedge clk);
      cyc++;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (bus.ack[i]) begin
            ack_log.push_back(i);
            ack_cyc[i] = cyc;
         end
      end
      if (bus.done != '0) begin
         done_cnt++;
         done_cyc.push_back(cyc);
         didx = 0;
         for (int unsigned i = 0; i < NREQ; i++) if (bus.done[i]) didx = i;
         chk("done_onehot", 64'($onehot(bus.done)), 64'(1));
         if (sb.size() == 0) begin
            chk("spurious_done", 64'(bus.done), 64'(0));
         end else begin
            e = sb.pop_front();
            chk("done_idx", 64'(didx), 64'(e.idx));
            chk("quot", 64'(bus.quot), 64'(e.q));
            chk("rem", 64'(bus.rem), 64'(e.r));
            chk("div0", 64'(bus.div0), 64'(e.z));
            chk("latency", 64'(cyc - ack_cyc[didx]), 64'(33));
         end
      end
   endtask

   task automatic do_reset();
      bus.req = '0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic drain(input int unsigned limit);
      for (int unsigned k = 0; k < limit && sb.size() > 0; k++) tick();
      if (sb.size() > 0) begin
         fail_msg("done_wait");
         sb.delete();
      end
   endtask

   task automatic do_single(input vec_t v);
      int unsigned n0;
      bit got;
      n0  = ack_log.size();
      got = 1'b0;
      bus.num[v.idx*NUM_W +: NUM_W] = v.n;
      bus.den[v.idx*DEN_W +: DEN_W] = v.d;
      bus.req[v.idx] = 1'b1;
      sb.push_back('{v.idx, v.q, v.r, v.z});
      for (int unsigned k = 0; k < 60 && !got; k++) begin
         tick();
         if (ack_log.size() > n0) got = 1'b1;
      end
      bus.req[v.idx] = 1'b0;
      if (!got) begin
         fail_msg("ack_wait");
         sb.delete();
      end else begin
         chk("ack_idx", 64'(ack_log[n0]), 64'(v.idx));
         tick();
         chk("busy_calc", 64'(bus.busy), 64'(1));
         drain(60);
      end
   endtask

   initial begin
      int unsigned n0, d0, acks0;
      bit got;

      vecs[0] = '{0, RPM_NUMERATOR, 16'd32000,  32'd2000,      16'd0,      1'b0};
      vecs[1] = '{1, 32'h1234_5678, 16'd0,      32'hFFFF_FFFF, 16'h5678,   1'b1};
      vecs[2] = '{2, 32'hFFFF_FFFF, 16'd1,      32'hFFFF_FFFF, 16'd0,      1'b0};
      vecs[3] = '{3, 32'd5,         16'd9,      32'd0,         16'd5,      1'b0};
      vecs[4] = '{1, 32'd1000,      16'd7,      32'd142,       16'd6,      1'b0};
      vecs[5] = '{2, 32'hFFFF_FFFF, 16'hFFFF,   32'h0001_0001, 16'd0,      1'b0};
      vecs[6] = '{0, 32'd0,         16'd5,      32'd0,         16'd0,      1'b0};
      vecs[7] = '{3, 32'd123456789, 16'd10000,  32'd12345,     16'd6789,   1'b0};

      bus.req = '0;
      bus.num = '0;
      bus.den = '0;
      #1 reset = 1'b1;
      #2;
      chk("rst_ack",  64'(bus.ack),  64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_quot", 64'(bus.quot), 64'(0));
      chk("rst_rem",  64'(bus.rem),  64'(0));
      chk("rst_div0", 64'(bus.div0), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      tick();
      reset = 1'b0;
      tick();

      for (int unsigned i = 0; i < 8; i++) do_single(vecs[i]);

      // All four requesters at once from reset: rotation 0,1,2,3, 34 cycles apart.
      do_reset();
      n0 = ack_log.size();
      d0 = done_cyc.size();
      for (int unsigned i = 0; i < NREQ; i++) begin
         bus.num[i*NUM_W +: NUM_W] = NUM_W'(100 * (i + 1));
         bus.den[i*DEN_W +: DEN_W] = DEN_W'(7);
      end
      bus.req = '1;
      sb.push_back('{0, 32'd14, 16'd2, 1'b0});
      sb.push_back('{1, 32'd28, 16'd4, 1'b0});
      sb.push_back('{2, 32'd42, 16'd6, 1'b0});
      sb.push_back('{3, 32'd57, 16'd1, 1'b0});
      for (int unsigned k = 0; k < 200 && sb.size() > 0; k++) begin
         tick();
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
               bus.req[i] = 1'b0;
               bus.num[i*NUM_W +: NUM_W] = 32'hDEAD_BEEF;
               bus.den[i*DEN_W +: DEN_W] = 16'd1;
            end
         end
      end
      if (sb.size() > 0) begin
         fail_msg("multi_done_wait");
         sb.delete();
      end
      chk("multi_ack_count", 64'(ack_log.size() - n0), 64'(4));
      if (ack_log.size() - n0 == 4) begin
         for (int unsigned i = 0; i < 4; i++) chk("multi_ack_order", 64'(ack_log[n0+i]), 64'(i));
      end
      if (done_cyc.size() - d0 == 4) begin
         for (int unsigned i = 1; i < 4; i++)
            chk("multi_done_gap", 64'(done_cyc[d0+i] - done_cyc[d0+i-1]), 64'(34));
      end else begin
         chk("multi_done_count", 64'(done_cyc.size() - d0), 64'(4));
      end

      // Fairness: req[0] held through two grants, req[2] interleaves.
      do_reset();
      n0 = ack_log.size();
      acks0 = 0;
      bus.num[0*NUM_W +: NUM_W] = 32'd1000;
      bus.den[0*DEN_W +: DEN_W] = 16'd10;
      bus.num[2*NUM_W +: NUM_W] = 32'd77;
      bus.den[2*DEN_W +: DEN_W] = 16'd5;
      bus.req[0] = 1'b1;
      bus.req[2] = 1'b1;
      sb.push_back('{0, 32'd100, 16'd0, 1'b0});
      sb.push_back('{2, 32'd15,  16'd2, 1'b0});
      sb.push_back('{0, 32'd100, 16'd0, 1'b0});
      for (int unsigned k = 0; k < 200 && sb.size() > 0; k++) begin
         tick();
         if (bus.ack[2]) bus.req[2] = 1'b0;
         if (bus.ack[0]) begin
            acks0++;
            if (acks0 == 2) bus.req[0] = 1'b0;
         end
      end
      if (sb.size() > 0) begin
         fail_msg("fair_done_wait");
         sb.delete();
      end
      bus.req = '0;
      tick();
      chk("fair_ack_count", 64'(ack_log.size() - n0), 64'(3));
      if (ack_log.size() - n0 == 3) begin
         chk("fair_ack0", 64'(ack_log[n0]),   64'(0));
         chk("fair_ack1", 64'(ack_log[n0+1]), 64'(2));
         chk("fair_ack2", 64'(ack_log[n0+2]), 64'(0));
      end

      // Reset during CALC aborts the grant without a done pulse.
      do_reset();
      n0 = ack_log.size();
      got = 1'b0;
      bus.num[1*NUM_W +: NUM_W] = 32'd500;
      bus.den[1*DEN_W +: DEN_W] = 16'd3;
      bus.req[1] = 1'b1;
      for (int unsigned k = 0; k < 20 && !got; k++) begin
         tick();
         if (ack_log.size() > n0) got = 1'b1;
      end
      bus.req[1] = 1'b0;
      if (!got) fail_msg("abort_ack_wait");
      for (int unsigned k = 0; k < 10; k++) tick();
      chk("abort_busy_before", 64'(bus.busy), 64'(1));
      reset = 1'b1;
      #1;
      chk("abort_busy",  64'(bus.busy), 64'(0));
      chk("abort_quot",  64'(bus.quot), 64'(0));
      chk("abort_ack",   64'(bus.ack),  64'(0));
      tick();
      reset = 1'b0;
      d0 = done_cnt;
      for (int unsigned k = 0; k < 40; k++) tick();
      chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
      do_single('{1, 32'd500, 16'd3, 32'd166, 16'd2, 1'b0});

      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
